pipe_mw_skid_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_skid_ctrl.sv | 78 +++++++
 rtl/pipe_mw_skid_reg.sv | 91 +++++++++
 tb/tb_pipe_mw_skid_reg.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the MEM/WB pipeline boundary: occupancy states and the
// default-width payload carried from MEM into WB.
package pipe_pkg;

   localparam int DW_DEFAULT  = 32;
   localparam int RNW_DEFAULT = 5;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_state_t;

   typedef struct packed {
      logic                   wreg;
      logic                   m2reg;
      logic [DW_DEFAULT-1:0]  mo;
      logic [DW_DEFAULT-1:0]  alu;
      logic [RNW_DEFAULT-1:0] rn;
   } mw_payload_t;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Occupancy state machine for the MEM/WB skid register. Decides which slot
// loads each cycle; in_ready depends only on held state, never on out_ready.
module pipe_skid_ctrl
   import pipe_pkg::*;
(
   input  logic       clock,
   input  logic       resetn,
   input  logic       flush,
   input  logic       in_valid,
   input  logic       out_ready,
   output logic       load_m,
   output logic       load_s,
   output logic       m_from_s,
   output logic       in_ready,
   output logic       out_valid,
   output logic [1:0] occ
);

   occ_state_t state_q;
   occ_state_t state_d;
   logic       in_fire;
   logic       out_fire;

   assign in_ready  = resetn & (state_q != OCC_TWO);
   assign out_valid = (state_q != OCC_EMPTY);
   assign occ       = state_q;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   // State register; reset wins over everything and empties the buffer
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= OCC_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and slot-load strobes; flush drops any same-cycle accept
   always_comb begin
      state_d  = state_q;
      load_m   = 1'b0;
      load_s   = 1'b0;
      m_from_s = 1'b0;
      if (flush) begin
         state_d = OCC_EMPTY;
      end else begin
         case (state_q)
            OCC_EMPTY: begin
               if (in_fire) begin
                  load_m  = 1'b1;
                  state_d = OCC_ONE;
               end
            end
            OCC_ONE: begin
               if (in_fire && out_fire) begin
                  load_m = 1'b1;
               end else if (in_fire) begin
                  load_s  = 1'b1;
                  state_d = OCC_TWO;
               end else if (out_fire) begin
                  state_d = OCC_EMPTY;
               end
            end
            OCC_TWO: begin
               if (out_fire) begin
                  m_from_s = 1'b1;
                  state_d  = OCC_ONE;
               end
            end
            default: begin
               state_d = OCC_EMPTY;
            end
         endcase
      end
   end

endmodule

// File: rtl/pipe_mw_skid_reg.sv
// MEM/WB boundary register with a two-entry skid buffer. Slot M drives the
// writeback outputs; slot S catches the one instruction that arrives while
// WB stalls, so in_ready can stay a registered-state signal.
module pipe_mw_skid_reg
   import pipe_pkg::*;
#(
   parameter int DW  = 32,
   parameter int RNW = 5
)(
   input  logic           clock,
   input  logic           resetn,
   input  logic           flush,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           mwreg,
   input  logic           mm2reg,
   input  logic [DW-1:0]  mmo,
   input  logic [DW-1:0]  malu,
   input  logic [RNW-1:0] mrn,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           wwreg,
   output logic           wm2reg,
   output logic [DW-1:0]  wmo,
   output logic [DW-1:0]  walu,
   output logic [RNW-1:0] wrn,
   output logic [1:0]     occ
);

   typedef struct packed {
      logic           wreg;
      logic           m2reg;
      logic [DW-1:0]  mo;
      logic [DW-1:0]  alu;
      logic [RNW-1:0] rn;
   } slot_t;

   slot_t in_slot;
   slot_t m_q;
   slot_t s_q;
   logic  load_m;
   logic  load_s;
   logic  m_from_s;

   assign in_slot = '{wreg: mwreg, m2reg: mm2reg, mo: mmo, alu: malu, rn: mrn};

   pipe_skid_ctrl u_ctrl (
      .clock     (clock),
      .resetn    (resetn),
      .flush     (flush),
      .in_valid  (in_valid),
      .out_ready (out_ready),
      .load_m    (load_m),
      .load_s    (load_s),
      .m_from_s  (m_from_s),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .occ       (occ)
   );

   // Main slot: new input on pass-through, or promoted skid entry on drain
   always_ff @(posedge clock) begin
      if (!resetn) begin
         m_q <= '0;
      end else if (flush) begin
         m_q.wreg <= 1'b0;
      end else if (load_m) begin
         m_q <= in_slot;
      end else if (m_from_s) begin
         m_q <= s_q;
      end
   end

   // Skid slot: only captures while M is held by a stalled WB stage
   always_ff @(posedge clock) begin
      if (!resetn) begin
         s_q <= '0;
      end else if (flush) begin
         s_q.wreg <= 1'b0;
      end else if (load_s) begin
         s_q <= in_slot;
      end
   end

   assign wwreg  = m_q.wreg & out_valid;
   assign wm2reg = m_q.m2reg;
   assign wmo    = m_q.mo;
   assign walu   = m_q.alu;
   assign wrn    = m_q.rn;

endmodule

// File: tb/tb_pipe_mw_skid_reg.sv
// Bench for pipe_mw_skid_reg: a directed table of cycle vectors with
// hand-derived expectations, then random traffic against a queue model.
module tb_pipe_mw_skid_reg;
   import pipe_pkg::*;

   logic        clock;
   logic        resetn;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic        mwreg;
   logic        mm2reg;
   logic [31:0] mmo;
   logic [31:0] malu;
   logic [4:0]  mrn;
   logic        out_valid;
   logic        out_ready;
   logic        wwreg;
   logic        wm2reg;
   logic [31:0] wmo;
   logic [31:0] walu;
   logic [4:0]  wrn;
   logic [1:0]  occ;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] wrote = '0;

   typedef struct {
      logic        rstn;
      logic        fl;
      logic        iv;
      logic        ordy;
      mw_payload_t pin;
      logic        e_ov;
      logic        e_ir;
      logic [1:0]  e_occ;
      logic        chk;
      mw_payload_t pexp;
   } vec_t;

   vec_t        vecs[$];
   mw_payload_t model_q[$];
   logic        zeroed;

   pipe_mw_skid_reg #(.DW(32), .RNW(5)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mwreg     (mwreg),
      .mm2reg    (mm2reg),
      .mmo       (mmo),
      .malu      (malu),
      .mrn       (mrn),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .wwreg     (wwreg),
      .wm2reg    (wm2reg),
      .wmo       (wmo),
      .walu      (walu),
      .wrn       (wrn),
      .occ       (occ)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Regfile write monitor: records which registers WB actually wrote
   always @(posedge clock) begin
      if (resetn && out_valid && out_ready && wwreg) begin
         wrote[wrn] <= 1'b1;
      end
   end

   function automatic mw_payload_t mkp(input logic wr, input logic [4:0] rn);
      mw_payload_t p;
      p.wreg  = wr;
      p.m2reg = rn[0];
      p.mo    = 32'hA000_0000 | 32'(rn);
      p.alu   = 32'h0000_0100 + 32'(rn);
      p.rn    = rn;
      return p;
   endfunction

   task automatic addVec(input logic rstn, input logic fl, input logic iv, input logic ordy,
                         input mw_payload_t pin, input logic e_ov, input logic e_ir,
                         input logic [1:0] e_occ, input logic chk, input mw_payload_t pexp);
      vec_t v;
      v.rstn = rstn; v.fl = fl; v.iv = iv; v.ordy = ordy; v.pin = pin;
      v.e_ov = e_ov; v.e_ir = e_ir; v.e_occ = e_occ; v.chk = chk; v.pexp = pexp;
      vecs.push_back(v);
   endtask

   task automatic addStd(input logic rstn, input logic fl, input logic iv, input logic ordy,
                         input logic in_wr, input logic [4:0] in_rn,
                         input logic e_ov, input logic e_ir, input logic [1:0] e_occ,
                         input logic chk, input logic e_wr, input logic [4:0] e_rn);
      addVec(rstn, fl, iv, ordy, mkp(in_wr, in_rn), e_ov, e_ir, e_occ, chk, mkp(e_wr, e_rn));
   endtask

   task automatic applyStimulus(input logic rstn, input logic fl, input logic iv,
                                input logic ordy, input mw_payload_t p);
      resetn    = rstn;
      flush     = fl;
      in_valid  = iv;
      out_ready = ordy;
      mwreg     = p.wreg;
      mm2reg    = p.m2reg;
      mmo       = p.mo;
      malu      = p.alu;
      mrn       = p.rn;
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input int idx, input logic e_ov,
                              input logic e_ir, input logic [1:0] e_occ, input logic chk,
                              input mw_payload_t e);
      logic bad;
      bad = 1'b0;
      vectors++;
      if (out_valid !== e_ov) begin
         $display("[TB] FAIL %s[%0d] out_valid got %b want %b", name, idx, out_valid, e_ov);
         bad = 1'b1;
      end
      if (in_ready !== e_ir) begin
         $display("[TB] FAIL %s[%0d] in_ready got %b want %b", name, idx, in_ready, e_ir);
         bad = 1'b1;
      end
      if (occ !== e_occ) begin
         $display("[TB] FAIL %s[%0d] occ got %0d want %0d", name, idx, occ, e_occ);
         bad = 1'b1;
      end
      if (wwreg !== e.wreg) begin
         $display("[TB] FAIL %s[%0d] wwreg got %b want %b", name, idx, wwreg, e.wreg);
         bad = 1'b1;
      end
      if (chk) begin
         if (wrn !== e.rn || walu !== e.alu || wmo !== e.mo || wm2reg !== e.m2reg) begin
            $display("[TB] FAIL %s[%0d] data got rn=%0d alu=%h mo=%h m2=%b want rn=%0d alu=%h mo=%h m2=%b",
                     name, idx, wrn, walu, wmo, wm2reg, e.rn, e.alu, e.mo, e.m2reg);
            bad = 1'b1;
         end
      end
      if (bad) miscompares++;
   endtask

   task automatic checkFlag(input string name, input logic got, input logic want);
      vectors++;
      if (got !== want) begin
         $display("[TB] FAIL %s got %b want %b", name, got, want);
         miscompares++;
      end
   endtask

   // Advance the queue model by one clock edge using the inputs just applied
   task automatic modelStep(input logic rstn, input logic fl, input logic iv,
                            input logic ordy, input mw_payload_t p);
      logic accept;
      logic consume;
      if (!rstn) begin
         model_q.delete();
         zeroed = 1'b1;
      end else begin
         accept  = iv && (model_q.size() < 2);
         consume = ordy && (model_q.size() > 0);
         zeroed  = 1'b0;
         if (fl) begin
            model_q.delete();
         end else begin
            if (consume) void'(model_q.pop_front());
            if (accept) model_q.push_back(p);
         end
      end
   endtask

   initial begin
      mw_payload_t z;
      mw_payload_t p;
      mw_payload_t e;
      logic        rstn;
      logic        fl;
      logic        iv;
      logic        ordy;
      logic        prev_reset;

      z = '0;
      resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      mwreg = 1'b0; mm2reg = 1'b0; mmo = '0; malu = '0; mrn = '0;

      // reset: everything zero, not ready while reset is held
      addVec(0, 0, 0, 0, mkp(1, 14), 0, 0, 2'd0, 1, z);
      addVec(0, 0, 1, 1, mkp(1, 14), 0, 0, 2'd0, 1, z);
      addVec(1, 0, 0, 1, mkp(1, 14), 0, 1, 2'd0, 1, z);
      // single instruction, one-cycle latency, then drained
      p = '{wreg: 1'b1, m2reg: 1'b0, mo: 32'hDEADBEEF, alu: 32'h0000_0010, rn: 5'd5};
      addVec(1, 0, 1, 1, p, 1, 1, 2'd1, 1, p);
      addStd(1, 0, 0, 1, 0, 0, 0, 1, 2'd0, 0, 0, 0);
      // streaming rn=1..8 at full throughput
      for (int k = 1; k <= 8; k++) begin
         addStd(1, 0, 1, 1, 1, 5'(k), 1, 1, 2'd1, 1, 1, 5'(k));
      end
      addStd(1, 0, 0, 1, 0, 0, 0, 1, 2'd0, 0, 0, 0);
      // back-pressure: 3 and 4 held, 5 refused until drain
      addStd(1, 0, 1, 0, 1, 3, 1, 1, 2'd1, 1, 1, 3);
      addStd(1, 0, 1, 0, 1, 4, 1, 0, 2'd2, 1, 1, 3);
      addStd(1, 0, 1, 0, 1, 5, 1, 0, 2'd2, 1, 1, 3);
      addStd(1, 0, 1, 1, 1, 5, 1, 1, 2'd1, 1, 1, 4);
      addStd(1, 0, 1, 1, 1, 5, 1, 1, 2'd1, 1, 1, 5);
      addStd(1, 0, 0, 1, 0, 0, 0, 1, 2'd0, 0, 0, 0);
      // flush while full with rn=9 offered the same cycle
      addStd(1, 0, 1, 0, 1, 10, 1, 1, 2'd1, 1, 1, 10);
      addStd(1, 0, 1, 0, 1, 11, 1, 0, 2'd2, 1, 1, 10);
      addStd(1, 1, 1, 0, 1, 9, 0, 1, 2'd0, 0, 0, 0);
      addStd(1, 0, 0, 1, 0, 0, 0, 1, 2'd0, 0, 0, 0);
      // reset while full, then fresh rn=7
      addStd(1, 0, 1, 0, 1, 12, 1, 1, 2'd1, 1, 1, 12);
      addStd(1, 0, 1, 0, 1, 13, 1, 0, 2'd2, 1, 1, 12);
      addVec(0, 0, 1, 1, mkp(1, 14), 0, 0, 2'd0, 1, z);
      addVec(1, 0, 0, 1, mkp(1, 14), 0, 1, 2'd0, 1, z);
      addStd(1, 0, 1, 1, 1, 7, 1, 1, 2'd1, 1, 1, 7);
      // bubble to r31 must show but never write
      addStd(1, 0, 1, 1, 0, 31, 1, 1, 2'd1, 1, 0, 31);
      addStd(1, 0, 0, 1, 0, 0, 0, 1, 2'd0, 0, 0, 0);

      $display("[TB] directed table: %0d vectors", vecs.size());
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rstn, vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].pin);
         checkOutput("table", i, vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_occ, vecs[i].chk,
                     vecs[i].pexp);
      end
      checkFlag("regfile_r31_bubble_no_write", wrote[31], 1'b0);
      checkFlag("regfile_r5_written", wrote[5], 1'b1);
      checkFlag("regfile_r9_flushed_no_write", wrote[9], 1'b0);

      // random traffic against the queue model
      model_q.delete();
      zeroed     = 1'b0;
      prev_reset = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         rstn = (c == 0) ? 1'b0 : ($urandom_range(63) != 0);
         fl   = ($urandom_range(39) == 0);
         iv   = prev_reset ? 1'b0 : ($urandom_range(9) < 7);
         ordy = ($urandom_range(9) < 6);
         p.wreg  = 1'($urandom_range(1));
         p.m2reg = 1'($urandom_range(1));
         p.mo    = $urandom();
         p.alu   = $urandom();
         p.rn    = 5'($urandom_range(31));
         applyStimulus(rstn, fl, iv, ordy, p);
         modelStep(rstn, fl, iv, ordy, p);
         e = '0;
         if (model_q.size() > 0) e = model_q[0];
         checkOutput("rand", c, model_q.size() > 0, rstn && (model_q.size() < 2),
                     2'(model_q.size()), (model_q.size() > 0) || zeroed, e);
         prev_reset = !rstn;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
